// File: rtl/sseg_stopwatch_if.sv
// Display bus from the stopwatch to the four-digit seven-segment multiplexer.
interface sseg_stopwatch_if;
    logic       enabled;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;

    modport master (output enabled, digit0, digit1, digit2, digit3);
    modport slave  (input  enabled, digit0, digit1, digit2, digit3);
endinterface

// File: rtl/sseg_stopwatch.sv
// Four-digit BCD stopwatch with start/stop and clear buttons, a tick prescaler
// and a free-running refresh strobe for the seven-segment multiplexer.
module sseg_stopwatch #(
    parameter int unsigned TICK_DIV    = 1000000,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_stop,
    input  logic              clear,
    output logic              running,
    output logic              overflow,
    sseg_stopwatch_if.master  disp
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t             state;
    logic               ss_prev;
    logic               clr_prev;
    logic [PW-1:0]      presc;
    logic [RW-1:0]      rcnt;
    logic [RW-1:0]      rcnt_nxt;
    logic [3:0][3:0]    bcd;
    logic [3:0][3:0]    bcd_inc;
    logic               carry;
    logic               enabled_q;
    logic               ss_ev;
    logic               clr_ev;
    logic               tick;

    assign ss_ev  = start_stop & ~ss_prev;
    assign clr_ev = clear & ~clr_prev;
    assign tick   = (state == RUN) && (presc == PRESC_MAX);

    assign rcnt_nxt = (rcnt == REF_MAX) ? '0 : rcnt + RW'(1);

    // Decimal ripple: carry survives the loop only when every digit was 9.
    always_comb begin
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd[i] == 4'd9) begin
                    bcd_inc[i] = '0;
                end else begin
                    bcd_inc[i] = bcd[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ss_prev   <= 1'b0;
            clr_prev  <= 1'b0;
            presc     <= '0;
            rcnt      <= '0;
            bcd       <= '0;
            enabled_q <= 1'b0;
            running   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ss_prev   <= start_stop;
            clr_prev  <= clear;
            rcnt      <= rcnt_nxt;
            enabled_q <= (rcnt_nxt == REF_MAX);

            if (clr_ev) begin
                state    <= IDLE;
                presc    <= '0;
                bcd      <= '0;
                overflow <= 1'b0;
                running  <= 1'b0;
            end else begin
                // Counting uses the pre-edge state, so a stop on a tick edge still increments.
                if (state == RUN) begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        bcd <= bcd_inc;
                        if (carry) overflow <= 1'b1;
                    end
                end
                if (ss_ev) begin
                    case (state)
                        IDLE: begin state <= RUN;  running <= 1'b1; end
                        RUN:  begin state <= STOP; running <= 1'b0; end
                        STOP: begin state <= RUN;  running <= 1'b1; end
                        default: begin state <= IDLE; running <= 1'b0; end
                    endcase
                end
            end
        end
    end

    assign disp.enabled = enabled_q;
    assign disp.digit0  = bcd[0];
    assign disp.digit1  = bcd[1];
    assign disp.digit2  = bcd[2];
    assign disp.digit3  = bcd[3];

endmodule

// File: tb/tb_sseg_stopwatch.sv
// Directed and randomized bench for sseg_stopwatch against a cycle-level
// arithmetic model of count, tick phase, run mode and refresh strobe.
module tb_sseg_stopwatch;

    localparam int unsigned TD = 4;
    localparam int unsigned RD = 5;

    logic clk = 1'b0;
    logic rst;
    logic start_stop;
    logic clear;
    logic running;
    logic overflow;

    sseg_stopwatch_if disp();

    sseg_stopwatch #(.TICK_DIV(TD), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .running    (running),
        .overflow   (overflow),
        .disp       (disp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = idle, 1 = run, 2 = stopped; count is 0..9999.
    int m_mode;
    int m_count;
    int m_phase;
    int m_edges;
    bit m_ovf;
    bit m_ss_prev;
    bit m_clr_prev;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_digits();
        return {disp.digit3, disp.digit2, disp.digit1, disp.digit0};
    endfunction

    task automatic mdl_reset();
        m_mode = 0; m_count = 0; m_phase = 0; m_edges = 0;
        m_ovf = 1'b0; m_ss_prev = 1'b0; m_clr_prev = 1'b0;
    endtask

    task automatic mdl_edge(input bit ss, input bit clr);
        bit ev_ss, ev_clr;
        ev_ss  = ss && !m_ss_prev;
        ev_clr = clr && !m_clr_prev;
        m_ss_prev  = ss;
        m_clr_prev = clr;
        m_edges++;
        if (m_mode == 1) begin
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_count = (m_count + 1) % 10000;
                if (m_count == 0) m_ovf = 1'b1;
            end
        end
        if (ev_clr) begin
            m_mode = 0; m_count = 0; m_phase = 0; m_ovf = 1'b0;
        end else if (ev_ss) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("digits",   32'(dut_digits()), 32'(to_bcd(m_count)));
        chk("enabled",  32'(disp.enabled), 32'((m_edges % RD) == RD - 1));
        chk("running",  32'(running),      32'(m_mode == 1));
        chk("overflow", 32'(overflow),     32'(m_ovf));
    endtask

    task automatic tick(input bit ss, input bit clr);
        start_stop = ss;
        clear      = clr;
        @(posedge clk);
        mdl_edge(ss, clr);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_digits"},   32'(dut_digits()), 32'h0);
        chk({tag, "_enabled"},  32'(disp.enabled), 32'h0);
        chk({tag, "_running"},  32'(running),      32'h0);
        chk({tag, "_overflow"}, 32'(overflow),     32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ss_lvl;
        bit clr_lvl;

        // Reset and idle refresh strobes
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (12) tick(1'b0, 1'b0);
        chk("idle_digits", 32'(dut_digits()), 32'h0);

        // Start: held level gives one toggle, then count
        tick(1'b1, 1'b0);
        chk("start_running", 32'(running), 32'h1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("first_inc", 32'(dut_digits()), 32'h0001);
        repeat (4) tick(1'b0, 1'b0);
        chk("second_inc", 32'(dut_digits()), 32'h0002);
        repeat (32) tick(1'b0, 1'b0);
        chk("tens_roll", 32'(dut_digits()), 32'h0010);

        // Stop with prescaler retained at 2, then resume
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("stop_running", 32'(running), 32'h0);
        repeat (20) tick(1'b0, 1'b0);
        chk("frozen", 32'(dut_digits()), 32'h0010);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("resume_wait", 32'(dut_digits()), 32'h0010);
        tick(1'b0, 1'b0);
        chk("resume_inc", 32'(dut_digits()), 32'h0011);

        // Overflow: 9989 more ticks bring 0011 to 10000
        repeat (9989 * TD) tick(1'b0, 1'b0);
        chk("ovf_digits",  32'(dut_digits()), 32'h0000);
        chk("ovf_flag",    32'(overflow),     32'h1);
        chk("ovf_running", 32'(running),      32'h1);
        tick(1'b0, 1'b1);
        chk("clr_ovf",     32'(overflow),     32'h0);
        chk("clr_running", 32'(running),      32'h0);
        chk("clr_digits",  32'(dut_digits()), 32'h0);
        tick(1'b0, 1'b0);

        // Simultaneous clear and start_stop while running
        tick(1'b1, 1'b0);
        repeat (7) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("simul_running", 32'(running),      32'h0);
        chk("simul_digits",  32'(dut_digits()), 32'h0);
        tick(1'b0, 1'b0);

        // Random button activity
        ss_lvl = 1'b0; clr_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  ss_lvl  = ~ss_lvl;
            if ($urandom_range(0, 39) == 0) clr_lvl = ~clr_lvl;
            tick(ss_lvl, clr_lvl);
        end

        // Async reset mid-cycle while running at 0123
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (123 * TD) tick(1'b0, 1'b0);
        chk("pre_rst_digits", 32'(dut_digits()), 32'h0123);
        #2 rst = 1'b1;
        #1 check_reset_values("async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        repeat (12) tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
